// File: rtl/rx2da_seq_pkg.sv
// Shared types and defaults for the rx2da capture/replay sequencer.
// Imported by the sequencer top.
package rx2da_seq_pkg;

    localparam int AW_DEF         = 13;
    localparam int DW_DEF         = 8;
    localparam int RD_LAT_DEF     = 2;
    localparam int OBUF_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PLAY    = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    function automatic int unsigned popcnt(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rx2da.sv
// Simple-dual-port 8-bit sample buffer with a pipelined read port:
// read register on ceb, output register on oce (2-cycle latency).
module rx2da #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clka,
    input  logic          cea,
    input  logic          reset,
    input  logic          clkb,
    input  logic          ceb,
    input  logic          oce,
    input  logic [AW-1:0] ada,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] adb,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clka) begin
        if (cea) begin
            mem[ada] <= din;
        end
    end

    always_ff @(posedge clkb or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
            dout <= '0;
        end else begin
            if (ceb) begin
                rd_q <= mem[adb];
            end
            if (oce) begin
                dout <= rd_q;
            end
        end
    end

endmodule

// File: rtl/rx2da_obuf.sv
// Small synchronous output FIFO; the count feeds the read-credit check.
// Flush takes priority over a same-cycle push or pop.
module rx2da_obuf #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= nxt(wr_q);
            end
            if (pop) begin
                rd_q <= nxt(rd_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign valid = (cnt_q != '0);
    assign dout  = valid ? mem[rd_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/rx2da_seq.sv
// Capture RX samples into rx2da, then replay them once or looping
// as a valid/ready stream; read latency is hidden by a credit FIFO.
module rx2da_seq
    import rx2da_seq_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW:0]   cap_len,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic [DW-1:0] da_data,
    output logic          da_valid,
    input  logic          da_ready,
    output logic [1:0]    state,
    output logic          done,
    output logic          len_err
);

    localparam int CW = $clog2(OBUF_DEPTH + 1);

    state_e            state_q;
    logic [AW-1:0]     wr_addr_q;
    logic [AW-1:0]     rd_addr_q;
    logic [AW-1:0]     last_q;
    logic [RD_LAT-1:0] vld_q;
    logic              done_q;
    logic              len_err_q;

    logic [CW-1:0]     ob_cnt;
    logic [DW-1:0]     ram_dout;
    int unsigned       inflight;
    int unsigned       occ;
    logic              legal;
    logic              credit;
    logic              wr_en;
    logic              rd_en;
    logic              push;
    logic              pop;
    logic              drained;

    assign legal = (cap_len != '0) && (cap_len <= {1'b1, {AW{1'b0}}});

    // Reads in flight plus buffered samples must fit the FIFO.
    assign inflight = popcnt(32'(vld_q));
    assign occ      = inflight + 32'(ob_cnt);
    assign credit   = (occ < 32'(OBUF_DEPTH));

    assign wr_en = (state_q == CAPTURE) && rx_valid && !stop;
    assign rd_en = (state_q == PLAY) && credit && !stop;
    assign push  = vld_q[RD_LAT-1];
    assign pop   = da_valid && da_ready;

    assign drained = (inflight == 0) &&
                     ((ob_cnt == '0) || ((ob_cnt == CW'(1)) && pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            last_q    <= '0;
            vld_q     <= '0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            vld_q  <= stop ? '0 : ((vld_q << 1) | RD_LAT'(rd_en));
            unique case (state_q)
                IDLE: begin
                    if (arm && !stop) begin
                        if (legal) begin
                            last_q    <= cap_len[AW-1:0] - 1'b1;
                            wr_addr_q <= '0;
                            len_err_q <= 1'b0;
                            state_q   <= CAPTURE;
                        end else begin
                            len_err_q <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (rx_valid) begin
                        wr_addr_q <= wr_addr_q + 1'b1;
                        if (wr_addr_q == last_q) begin
                            rd_addr_q <= '0;
                            state_q   <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (rd_en) begin
                        if (rd_addr_q == last_q) begin
                            rd_addr_q <= '0;
                            if (!loop_en) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (drained) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    rx2da #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clka  (clk),
        .cea   (wr_en),
        .reset (reset),
        .clkb  (clk),
        .ceb   (rd_en),
        .oce   (1'b1),
        .ada   (wr_addr_q),
        .din   (rx_data),
        .adb   (rd_addr_q),
        .dout  (ram_dout)
    );

    rx2da_obuf #(
        .DEPTH(OBUF_DEPTH),
        .DW   (DW)
    ) u_obuf (
        .clk   (clk),
        .reset (reset),
        .flush (stop),
        .push  (push),
        .din   (ram_dout),
        .pop   (pop),
        .dout  (da_data),
        .valid (da_valid),
        .count (ob_cnt)
    );

    assign state   = state_q;
    assign done    = done_q;
    assign len_err = len_err_q;

endmodule
